// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: types shared by the SPI bus arbiter, its interface and benches.
//   SlaveSelect   - slave-select code driven to the SPI master (SS_NONE = idle)
//   arb_state_e   - arbiter FSM state
//   ARB_OWN_0/1   - owner index values held in the arbiter's `last` register
package spi_arb_pkg;

    localparam int unsigned SPI_DW = 16;

    typedef enum logic [2:0] {
        SS_NONE = 3'b000,
        SS_CH0  = 3'b001,
        SS_CH1  = 3'b010,
        SS_CH2  = 3'b011,
        SS_CH3  = 3'b100
    } SlaveSelect;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN0  = 2'd1,
        ARB_OWN1  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_e;

    localparam logic ARB_OWN_0 = 1'b0;
    localparam logic ARB_OWN_1 = 1'b1;

    // Maps an owner index onto its ownership state.
    function automatic arb_state_e own_state(input logic idx);
        return (idx == ARB_OWN_1) ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/spi_arb_if.sv
// spi_arb_if: requester and SPI-master side signals of the SPI bus arbiter.
//   req0/1, wrt0/1, ss0/1, data0/1 : requester inputs
//   gnt0/1, done0/1                : per-requester grant and completion
//   wrt_SPI, ss, SPI_data, SPI_done: SPI master connection
//   busy, err                      : transfer-in-flight and error pulse
// Modport slave is the arbiter's view; master is the surrounding system.
interface spi_arb_if;
    import spi_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic              wrt0;
    logic              wrt1;
    SlaveSelect        ss0;
    SlaveSelect        ss1;
    logic [SPI_DW-1:0] data0;
    logic [SPI_DW-1:0] data1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic              wrt_SPI;
    SlaveSelect        ss;
    logic [SPI_DW-1:0] SPI_data;
    logic              SPI_done;
    logic              busy;
    logic              err;

    modport slave (
        input  req0, req1, wrt0, wrt1, ss0, ss1, data0, data1, SPI_done,
        output gnt0, gnt1, done0, done1, wrt_SPI, ss, SPI_data, busy, err
    );

    modport master (
        output req0, req1, wrt0, wrt1, ss0, ss1, data0, data1, SPI_done,
        input  gnt0, gnt1, done0, done1, wrt_SPI, ss, SPI_data, busy, err
    );

endinterface

// File: rtl/spi_arb_tmo.sv
// spi_arb_tmo: idle-owner timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (takes priority over en_i)
//   en_i       : count enable
//   expire_o   : high while enabled, not cleared and the count is TMO_CYC-1
module spi_arb_tmo #(
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o = en_i & ~clr_i & (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_arb.sv
// spi_arb: two-requester arbiter in front of a single SPI master.
// Requester 0 is the command dispatcher, requester 1 the calibration/EEPROM
// loader. Ownership spans multi-transfer sequences; the owner's ss/wrt/data
// are muxed onto the master and SPI_done is routed back to it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spi_arb_if.slave (requester and SPI master signals)
//   TMO_CYC    : idle cycles an owner may hold the grant before revocation
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_arb_if.slave   bus
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;     // owner index of the current/last grant
    logic [1:0]        blocked_q, blocked_d;
    logic              busy_q, busy_d;
    logic [1:0]        gnt_q, gnt_d;

    logic              own_st;
    logic              mux_en;
    logic              owner;
    logic              req_o;
    logic              wrt_o;
    SlaveSelect        ss_o;
    logic [SPI_DW-1:0] data_o;
    logic              accept;
    logic              collide;
    logic              tmo_clr;
    logic              tmo_exp;
    logic              revoke;
    logic              cand0, cand1;

    assign own_st = (state_q == ARB_OWN0) || (state_q == ARB_OWN1);
    assign mux_en = own_st || (state_q == ARB_DRAIN);
    assign owner  = last_q;

    assign req_o  = (owner == ARB_OWN_1) ? bus.req1  : bus.req0;
    assign wrt_o  = (owner == ARB_OWN_1) ? bus.wrt1  : bus.wrt0;
    assign ss_o   = (owner == ARB_OWN_1) ? bus.ss1   : bus.ss0;
    assign data_o = (owner == ARB_OWN_1) ? bus.data1 : bus.data0;

    // A completing transfer frees the master in the same cycle, so a wrt
    // coinciding with SPI_done is accepted back-to-back.
    assign accept  = own_st & wrt_o & (~busy_q | bus.SPI_done);
    assign collide = own_st & wrt_o & busy_q & ~bus.SPI_done;

    // Counter only runs while an owner sits idle; leaving OWNx clears it,
    // which also covers the clear-on-entry since OWNx is only entered from IDLE.
    assign tmo_clr = ~own_st | wrt_o | busy_q;

    spi_arb_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmo_clr),
        .en_i     (own_st),
        .expire_o (tmo_exp)
    );

    // A voluntary release in the expiry cycle is not treated as a timeout.
    assign revoke = tmo_exp & req_o;

    assign cand0 = bus.req0 & ~blocked_q[0];
    assign cand1 = bus.req1 & ~blocked_q[1];

    always_comb begin
        busy_d = busy_q;
        if (accept) begin
            busy_d = 1'b1;
        end else if (bus.SPI_done) begin
            busy_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        blocked_d = blocked_q & {bus.req1, bus.req0};
        case (state_q)
            ARB_IDLE: begin
                if (cand0 && cand1) begin
                    last_d  = ~last_q;
                    state_d = own_state(~last_q);
                end else if (cand0) begin
                    last_d  = ARB_OWN_0;
                    state_d = ARB_OWN0;
                end else if (cand1) begin
                    last_d  = ARB_OWN_1;
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (!req_o) begin
                    state_d = busy_d ? ARB_DRAIN : ARB_IDLE;
                end else if (revoke) begin
                    state_d = ARB_IDLE;
                    if (owner == ARB_OWN_1) begin
                        blocked_d[1] = 1'b1;
                    end else begin
                        blocked_d[0] = 1'b1;
                    end
                end
            end
            ARB_DRAIN: begin
                if (!busy_q || bus.SPI_done) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        gnt_d = {state_d == ARB_OWN1, state_d == ARB_OWN0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            last_q    <= ARB_OWN_1;
            blocked_q <= '0;
            busy_q    <= 1'b0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            blocked_q <= blocked_d;
            busy_q    <= busy_d;
            gnt_q     <= gnt_d;
        end
    end

    assign bus.gnt0     = gnt_q[0];
    assign bus.gnt1     = gnt_q[1];
    assign bus.wrt_SPI  = accept;
    assign bus.ss       = mux_en ? ss_o : SS_NONE;
    assign bus.SPI_data = mux_en ? data_o : '0;
    assign bus.done0    = mux_en & (owner == ARB_OWN_0) & bus.SPI_done;
    assign bus.done1    = mux_en & (owner == ARB_OWN_1) & bus.SPI_done;
    assign bus.busy     = busy_q;
    assign bus.err      = collide | revoke;

endmodule

// File: doc/spi_arb.md
# spi_arb

Two-requester arbiter that shares the single SPI master between the command dispatcher (requester 0) and the power-up calibration/EEPROM loader (requester 1). It grants bus ownership for multi-transfer sequences, such as the three-transfer EEPROM read, and muxes the owner's `ss`/`wrt_SPI`/`SPI_data` onto the master. It tracks the in-flight transfer so ownership never changes mid-transfer, and revokes ownership from a stalled owner.

## Interface
Parameters:
- `TMO_CYC`, default 1024: cycles an owner may hold the grant while idle (no transfer in flight, no `wrt`) before forced release.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1 each: request/hold bus; held high for the whole sequence.
- `wrt0`, `wrt1` in 1 each: transfer-start pulse from the requester.
- `ss0`, `ss1` in SlaveSelect each: slave select from the requester.
- `data0`, `data1` in 16 each: SPI word from the requester.
- `gnt0`, `gnt1` out 1 each: ownership grant (registered).
- `done0`, `done1` out 1 each: `SPI_done` routed to the owner.
- `wrt_SPI` out 1: to SPI master.
- `ss` out SlaveSelect: to SPI master.
- `SPI_data` out 16: to SPI master.
- `SPI_done` in 1: transfer complete from SPI master.
- `busy` out 1: transfer in flight.
- `err` out 1: one-cycle pulse on a protocol violation or timeout.

## Operation
- States:
  - IDLE: no owner.
  - OWN0, OWN1: one requester owns the bus.
  - DRAIN: owner has dropped; in-flight transfer is finishing.
- IDLE arbitration:
  - Only one `req` high: grant it.
  - Both high: round-robin, where a 1-bit `last` register records the last owner and the other requester wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- OWNx:
  - `ss = ssx`, `SPI_data = datax`, `wrt_SPI = wrtx & ~busy`. `donex = SPI_done`; the other requester's done is 0.
  - `busy` sets on an accepted `wrt_SPI` and clears on `SPI_done`.
  - `wrtx` while `busy`: dropped, `err` pulses.
  - `wrt` from the non-owner: ignored, no error.
- Release:
  - `reqx` falls with `busy` low: go to IDLE next cycle.
  - `reqx` falls with `busy` high: go to DRAIN. In DRAIN the mux holds the last owner, `gnt` is low, `donex` is still delivered, and the state goes to IDLE on `SPI_done`.
- Timeout:
  - A counter resets on each state entry, on `wrtx`, and while `busy`.
  - It increments in OWNx otherwise. On reaching `TMO_CYC-1`, the arbiter forces IDLE and pulses `err`.
  - The revoked requester cannot be regranted until its `req` has been low for at least 1 cycle. A per-requester `blocked` flag enforces this.
- Outside OWNx/DRAIN: `ss = SS_NONE`, `wrt_SPI = 0`, `SPI_data = 0`.
- `SPI_done` with `busy` low is ignored.

## Timing
- Reset values: state IDLE, `gnt0 = gnt1 = 0`, `busy = 0`, `err = 0`, `wrt_SPI = 0`, `ss = SS_NONE`, `SPI_data = 0`, `done0 = done1 = 0`, counter 0, `last = 1`, `blocked = 0`.
- Grant latency: `req` sampled high in IDLE, `gnt` high the next cycle. The earliest `wrt` passes through in that grant cycle.
- Handover: at least one IDLE cycle separates two owners, so the fastest A-to-B handover is 2 cycles after A drops `req`.
- `wrt_SPI`, `ss`, and `SPI_data` are combinational from the owner's inputs (zero latency). `done` is combinational from `SPI_done`.
- Simultaneous `SPI_done` and `wrtx` in the same cycle: the `wrt` is accepted (back-to-back transfer) and `busy` stays high.
- Simultaneous `reqx` fall and `SPI_done`: go directly to IDLE.
- Reset mid-transfer: all state clears immediately. The SPI master is reset by the same `rst_n`.

## Structure
- `SlaveSelect` (including `SS_NONE`) stays in the shared types package.
- The arbiter state enum and `ARB_OWN_*` encodings go in the same package for bench visibility.
- Optional sub-module `spi_arb_tmo`: the timeout counter, with inputs clear/enable and output expire.
- The remainder is one FSM plus the mux, in a single module.

## Test plan
- Only `req0` high, `wrt0` pulse with `data0 = 16'h1346` and `ss0 = SS_CH2`: `gnt0` high 1 cycle later; master sees `16'h1346` on `SS_CH2`; `done0` follows `SPI_done`; `done1 = 0`.
- `req0` and `req1` rise together after reset: `gnt0` first. After `req0` drops, IDLE for 1 cycle, then `gnt1`. Repeat the tie: `gnt0` wins again.
- Requester 0 performs a 3-transfer EEPROM read (`16'h0A00`, `16'h0000`, `16'h0000`) while `req1` is held: `gnt1` stays low until all 3 `SPI_done` pulses and `req0` drops.
- `req0` drops while `busy`: state DRAIN, `gnt0` low, `ss` held; IDLE on `SPI_done`; `req1` is granted on the following cycle.
- `wrt0` asserted while `busy`: master `wrt_SPI` stays 0, `err` pulses 1 cycle, in-flight transfer unaffected.
- `TMO_CYC = 8`, owner idle: `err` pulses on the 8th idle cycle, `gnt` drops; `req` held high is not regranted until it toggles low then high.
